// File: rtl/hex_ui_pkg.sv
// Shared types and board defaults for the hex-entry keypad/display front end.
// Defaults assume a 100 MHz board clock: 10 ms debounce and a 1 ms digit refresh.
package hex_ui_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_100MHZ = 1_000_000;
    localparam int unsigned REFRESH_CYCLES_100MHZ  = 100_000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw push button -> 2-flop synchronizer -> counter debounce -> 1-cycle rising-edge pulse.
// The pulse is high in the first cycle the debounced level reads 1; releases are silent.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic          last_d;

    assign last_d = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_q <= 1'b0;
            // Any cycle that agrees with the accepted level restarts the count.
            if (sync_q[1] != level_q) begin
                if (last_d) begin
                    level_q <= sync_q[1];
                    rise_q  <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/hex_entry_scan_ctrl.sv
// Builds an NUM_DIGITS-nibble word from switch entries (one per debounced ENTER) and
// time-multiplexes the partially/fully entered word onto active-low anodes.
module hex_entry_scan_ctrl
    import hex_ui_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int unsigned REFRESH_CYCLES  = REFRESH_CYCLES_100MHZ
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [3:0]                        switches_i,
    input  logic                              btn_enter_i,
    input  logic                              btn_clear_i,
    output logic [4*NUM_DIGITS-1:0]           value_o,
    output logic                              value_valid_o,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_count_o,
    output logic [NUM_DIGITS-1:0]             an_o,
    output logic [3:0]                        hex_digit_o
);

    localparam int unsigned W  = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);

    logic           enter_p;
    logic           clear_p;
    state_e         state_q;
    logic [W-1:0]   buf_q;
    logic [W-1:0]   buf_shift_d;
    logic [W-1:0]   value_q;
    logic           value_valid_q;
    logic [CW-1:0]  cnt_q;
    logic [RW-1:0]  refresh_q;
    logic [IW-1:0]  idx_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [3:0]     hex_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (btn_enter_i),
        .rise_o  (enter_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (btn_clear_i),
        .rise_o  (clear_p)
    );

    assign buf_shift_d = {buf_q[W-5:0], switches_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_EMPTY;
            buf_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            value_valid_q <= 1'b0;
            // Clear outranks a simultaneous enter; the published value survives a clear.
            if (clear_p) begin
                state_q <= ST_EMPTY;
                buf_q   <= '0;
                cnt_q   <= '0;
            end else if (enter_p && state_q != ST_FULL) begin
                buf_q <= buf_shift_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(NUM_DIGITS - 1)) begin
                    state_q       <= ST_FULL;
                    value_q       <= buf_shift_d;
                    value_valid_q <= 1'b1;
                end else begin
                    state_q <= ST_ENTRY;
                end
            end
        end
    end

    // Scan runs free of the FSM; digits at or above the entry count stay blanked.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            hex_q     <= '0;
        end else begin
            if (refresh_q == RW'(REFRESH_CYCLES - 1)) begin
                refresh_q <= '0;
                idx_q     <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
            hex_q <= buf_q[{idx_q, 2'b00} +: 4];
            an_q  <= (CW'(idx_q) < cnt_q) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        end
    end

    assign value_o       = value_q;
    assign value_valid_o = value_valid_q;
    assign entry_count_o = cnt_q;
    assign an_o          = an_q;
    assign hex_digit_o   = hex_q;

endmodule

// File: tb/tb_hex_entry_scan_ctrl.sv
// Directed + randomized bench: a queue of entered digits is the reference for count, value and display.
module tb_hex_entry_scan_ctrl;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RF = 3;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [3:0]  switches_i = 4'h0;
    logic        btn_enter_i = 1'b0;
    logic        btn_clear_i = 1'b0;
    logic [15:0] value_o;
    logic        value_valid_o;
    logic [2:0]  entry_count_o;
    logic [3:0]  an_o;
    logic [3:0]  hex_digit_o;

    int checks = 0;
    int errors = 0;
    int unsigned q[$];
    logic [15:0] mval = 16'h0;

    always #5 clk_i = ~clk_i;

    hex_entry_scan_ctrl #(
        .NUM_DIGITS      (N),
        .DEBOUNCE_CYCLES (DB),
        .REFRESH_CYCLES  (RF)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .switches_i    (switches_i),
        .btn_enter_i   (btn_enter_i),
        .btn_clear_i   (btn_clear_i),
        .value_o       (value_o),
        .value_valid_o (value_valid_o),
        .entry_count_o (entry_count_o),
        .an_o          (an_o),
        .hex_digit_o   (hex_digit_o)
    );

    function automatic logic [15:0] pack_q();
        logic [15:0] b;
        b = '0;
        foreach (q[i]) b = {b[11:0], 4'(q[i])};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input bit en, input bit cl, input logic [3:0] sw, output int vv);
        vv = 0;
        switches_i  = sw;
        btn_enter_i = en;
        btn_clear_i = cl;
        repeat (12) begin
            @(negedge clk_i);
            if (value_valid_o === 1'b1) vv++;
        end
        btn_enter_i = 1'b0;
        btn_clear_i = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (value_valid_o === 1'b1) vv++;
        end
    endtask

    task automatic do_press(input bit en, input bit cl, input logic [3:0] sw, input string tag);
        int vv;
        int exp_vv;
        press(en, cl, sw, vv);
        exp_vv = 0;
        if (cl) begin
            q.delete();
        end else if (en && q.size() < N) begin
            q.push_back(32'(sw));
            if (q.size() == N) begin
                mval   = pack_q();
                exp_vv = 1;
            end
        end
        chk({tag, "_vv"}, vv, exp_vv);
        chk({tag, "_cnt"}, entry_count_o, q.size());
        chk({tag, "_val"}, value_o, mval);
    endtask

    // Over 12 cycles the scan visits every index once for RF cycles each.
    task automatic check_display(input string tag);
        int  k;
        int  prev;
        int  run;
        int  seen;
        bit  shape_ok;
        bit  nib_ok;
        bit  order_ok;
        bit  len_ok;
        bit  first_run;
        prev = -2; run = 0; seen = 0;
        shape_ok = 1; nib_ok = 1; order_ok = 1; len_ok = 1; first_run = 1;
        repeat (12) begin
            @(negedge clk_i);
            k = -1;
            for (int j = 0; j < N; j++)
                if (an_o === ~(4'b0001 << j)) k = j;
            if (an_o === 4'b1111) begin
                if (hex_digit_o !== 4'h0) nib_ok = 0;
            end else if (k < 0 || k >= q.size()) begin
                shape_ok = 0;
            end else begin
                seen |= (1 << k);
                if (hex_digit_o !== 4'(q[q.size() - 1 - k])) nib_ok = 0;
            end
            if (k == prev) begin
                run++;
            end else begin
                if (prev != -2) begin
                    if (!first_run && q.size() == N && run != RF) len_ok = 0;
                    if (q.size() == N && k != (prev + 1) % N) order_ok = 0;
                    first_run = 0;
                end
                prev = k;
                run  = 1;
            end
        end
        chk({tag, "_shape"}, shape_ok, 1);
        chk({tag, "_nib"}, nib_ok, 1);
        chk({tag, "_seen"}, seen, (1 << q.size()) - 1);
        if (q.size() == N) begin
            chk({tag, "_order"}, order_ok, 1);
            chk({tag, "_runlen"}, len_ok, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, an_o, 4'b1111);
        chk({tag, "_val"}, value_o, 16'h0);
        chk({tag, "_vv"}, value_valid_o, 1'b0);
        chk({tag, "_cnt"}, entry_count_o, 0);
        chk({tag, "_hex"}, hex_digit_o, 4'h0);
    endtask

    initial begin
        logic [3:0] sw;
        int r;

        // 1. reset
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("rst");
        reset_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("rst_rel");

        // 2. bouncing enter yields nothing until a stable hold, then exactly one digit
        switches_i = 4'h7;
        for (int t = 0; t < 10; t++) begin
            btn_enter_i = ~btn_enter_i;
            repeat (2) @(negedge clk_i);
        end
        chk("bounce_cnt", entry_count_o, 0);
        btn_enter_i = 1'b1;
        repeat (8) @(negedge clk_i);
        btn_enter_i = 1'b0;
        repeat (12) @(negedge clk_i);
        q.push_back(32'h7);
        chk("bounce_one", entry_count_o, 1);
        check_display("disp_one");
        do_press(1'b0, 1'b1, 4'h0, "clr0");

        // 3. full word, then an ignored 5th press
        do_press(1'b1, 1'b0, 4'hA, "eA");
        do_press(1'b1, 1'b0, 4'hB, "eB");
        check_display("disp_two");
        do_press(1'b1, 1'b0, 4'hC, "eC");
        do_press(1'b1, 1'b0, 4'hD, "eD");
        chk("word_abcd", value_o, 16'hABCD);
        do_press(1'b1, 1'b0, 4'hF, "e5th");

        // 4. full scan
        check_display("disp_full");

        // 5. clear and enter together after two digits
        do_press(1'b0, 1'b1, 4'h0, "clr1");
        do_press(1'b1, 1'b0, 4'(($urandom_range(0, 15))), "p5a");
        do_press(1'b1, 1'b0, 4'(($urandom_range(0, 15))), "p5b");
        do_press(1'b1, 1'b1, 4'h9, "both");
        chk("both_an", an_o, 4'b1111);
        chk("both_keep", value_o, 16'hABCD);
        check_display("disp_empty");

        // 6. reset mid-word, then restart from empty
        do_press(1'b1, 1'b0, 4'h3, "p6a");
        do_press(1'b1, 1'b0, 4'h4, "p6b");
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        q.delete();
        mval = 16'h0;
        @(negedge clk_i);
        check_reset_outputs("rst2");
        do_press(1'b1, 1'b0, 4'h5, "p6c");

        // randomized presses and clears against the queue model
        for (int it = 0; it < 20; it++) begin
            r  = $urandom_range(0, 6);
            sw = 4'($urandom_range(0, 15));
            do_press(r != 0, r == 0 || r == 6, sw, "rnd");
            if (it % 4 == 3) check_display("rnd_disp");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
